mmio_io_hub: RTL and testbench
==============================

// Module: mmio_io_hub
// PURPOSE
//  Parametrised memory-mapped I/O hub between the core's load/store port and its targets.
//  Decodes each access to one of two targets: the data-memory window or an internal I/O register bank.
//  The I/O bank holds debounced switches, sticky switch-change flags, LEDs and the 7-seg value.
//  All reads complete with a fixed 1-cycle latency, and unmapped or illegal accesses raise a bus error.
//  Replaces the fixed one-switch/one-LED decode.
// PARAMETERS
//  ADDR_W        32            address width
//  DATA_W        32            data width (>= SW_W, LED_W, 16)
//  SW_W          16            switch inputs
//  LED_W         16            LED outputs
//  DMEM_BASE     32'h0000_0000 data-memory window base; aligned to 2**DMEM_AW
//  DMEM_AW       9             log2 of data-memory window size in bytes
//  IO_BASE       32'h0000_0200 I/O bank base; 16-byte window, must not overlap DMEM
//  DEBOUNCE_CYC  1000          stable cycles required before the switch value updates (>=2)
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        asynchronous, active-low reset
//  address        in   ADDR_W   byte address of the access
//  readEnable     in   1        read strobe, 1 cycle per access
//  writeEnable    in   1        write strobe, 1 cycle per access
//  writeData      in   DATA_W   store data
//  readData       out  DATA_W   load data, valid while readValid=1
//  readValid      out  1        pulses 1 cycle after an accepted read
//  busError       out  1        pulses 1 cycle after an illegal access
//  switches       in   SW_W     raw, asynchronous switch pins
//  leds           out  LED_W    LED register
//  segValue       out  16       value sent to the 7-seg driver
//  swIrq          out  1        OR of all SW_EDGE bits
//  dmemReadEnable out  1        data-memory read strobe (combinational)
//  dmemWriteEnable out 1        data-memory write strobe (combinational)
//  dmemAddress    out  DMEM_AW  offset into the window, i.e. address - DMEM_BASE
//  dmemWriteData  out  DATA_W   equals writeData
//  dmemReadData   in   DATA_W   data-memory read data, valid in the same cycle as the strobe
// BEHAVIOUR
//  Reset (rst=0, async): all registers and outputs go to 0, including the debounce counter and sync flops.
//  Decode (combinational):
//   - DMEM hit: address[ADDR_W-1:DMEM_AW] == DMEM_BASE[ADDR_W-1:DMEM_AW].
//   - IO hit: address[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4].
//   - dmem strobes = enable && DMEM hit && no error.
//  I/O map (offset = address[3:0]):
//   - 0x0 SW_VAL   RO   debounced switches
//   - 0x4 SW_EDGE  W1C  sticky change flags
//   - 0x8 LED      RW   [LED_W-1:0]
//   - 0xC SEG      RW   [15:0]
//   - Unused high bits read as 0.
//  Errors:
//   - Conditions: no hit; IO hit with address[1:0] != 0; readEnable and writeEnable both 1.
//   - busError=1 at the next cycle; no register or memory side effects.
//   - readValid=0 and readData=0 for an errored access.
//  Read timing:
//   - Accepted read in cycle N (DMEM sample of dmemReadData, or IO register value) is registered at edge N.
//   - readData/readValid are presented in cycle N+1.
//   - readData holds its value until the next accepted read; readValid is a 1-cycle pulse.
//   - Back-to-back reads are allowed, one per cycle.
//  Writes take effect at the clock edge; a read of the same register in the next cycle returns the new value.
//  Switch path:
//   - 2-flop synchroniser (sync) feeding one shared counter cnt.
//   - If sync != SW_VAL then cnt++; else cnt=0.
//   - When cnt == DEBOUNCE_CYC-1 and sync still differs: SW_VAL <= sync, cnt <= 0,
//     SW_EDGE |= (SW_VAL ^ sync).
//   - A bounce back to SW_VAL before terminal count clears cnt.
//  SW_EDGE write: bits written 1 are cleared.
//   - A set and a clear of the same bit in the same cycle leave the bit set.
//   - swIrq is registered, so it follows SW_EDGE with zero extra lag.
//  Reset asserted mid-access: pending readValid/busError are dropped. A pending debounce restarts from cnt=0.
// TESTING
//  1. Reset: drive rst=0 with switches=16'hFFFF -> all outputs 0.
//     Release reset -> SW_VAL reads 16'hFFFF only after 2+DEBOUNCE_CYC cycles.
//  2. Write LED 0x1234 at IO_BASE+8, then read IO_BASE+8 next cycle.
//     -> leds=16'h1234; readValid=1 one cycle later with readData=32'h1234.
//  3. Read DMEM offset 0x10 with dmemReadData=32'hDEADBEEF.
//     -> dmemAddress=0x10 and dmemReadEnable=1 in cycle N; readData=32'hDEADBEEF and readValid=1 in N+1.
//  4. Toggle switch[3] for DEBOUNCE_CYC/2 then revert -> no change.
//     Hold toggled -> SW_VAL[3]=1, SW_EDGE=16'h0008, swIrq=1.
//     Write 0x8 to SW_EDGE -> swIrq=0.
//  5. Errors: read IO_BASE+2; read 32'h0000_1000; assert readEnable and writeEnable together.
//     -> busError pulses, readValid=0, no dmem strobes, LED/SEG unchanged.
//  6. Force a debounce update in the same cycle as a W1C write of that bit -> SW_EDGE bit remains 1.

Source files
------------

// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: decodes core load/store accesses to a data-memory
// window or a small I/O register bank (debounced switches, sticky change
// flags, LEDs, 7-segment value). Reads return after one cycle; illegal or
// unmapped accesses report a one-cycle bus error and have no side effects.
module mmio_io_hub #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                SW_W         = 16,
    parameter int                LED_W        = 16,
    parameter logic [ADDR_W-1:0] DMEM_BASE    = 32'h0000_0000,
    parameter int                DMEM_AW      = 9,
    parameter logic [ADDR_W-1:0] IO_BASE      = 32'h0000_0200,
    parameter int                DEBOUNCE_CYC = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  address,
    input  logic               readEnable,
    input  logic               writeEnable,
    input  logic [DATA_W-1:0]  writeData,
    output logic [DATA_W-1:0]  readData,
    output logic               readValid,
    output logic               busError,
    input  logic [SW_W-1:0]    switches,
    output logic [LED_W-1:0]   leds,
    output logic [15:0]        segValue,
    output logic               swIrq,
    output logic               dmemReadEnable,
    output logic               dmemWriteEnable,
    output logic [DMEM_AW-1:0] dmemAddress,
    output logic [DATA_W-1:0]  dmemWriteData,
    input  logic [DATA_W-1:0]  dmemReadData
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    // I/O register offsets, selected by address[3:2]
    localparam logic [1:0] REG_SW_VAL  = 2'd0;
    localparam logic [1:0] REG_SW_EDGE = 2'd1;
    localparam logic [1:0] REG_LED     = 2'd2;
    localparam logic [1:0] REG_SEG     = 2'd3;

    logic              dmem_hit;
    logic              io_hit;
    logic              access;
    logic              err;
    logic              rd_ok;
    logic              io_wr;
    logic [DATA_W-1:0] io_rdata;

    logic [SW_W-1:0]   sync_a;
    logic [SW_W-1:0]   sync;
    logic [SW_W-1:0]   sw_val;
    logic [SW_W-1:0]   sw_edge;
    logic [CNT_W-1:0]  cnt;
    logic              deb_fire;
    logic [SW_W-1:0]   edge_set;
    logic [SW_W-1:0]   edge_clr;
    logic [SW_W-1:0]   edge_next;
    logic [LED_W-1:0]  led_reg;
    logic [15:0]       seg_reg;

    logic              unused_bits;

    // Upper store-data bits beyond the narrowest register are not stored anywhere
    assign unused_bits = ^writeData;

    assign dmem_hit = (address[ADDR_W-1:DMEM_AW] == DMEM_BASE[ADDR_W-1:DMEM_AW]);
    assign io_hit   = (address[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    assign access   = readEnable | writeEnable;

    // Decode: classify the access and derive the data-memory strobes
    always_comb begin
        err = 1'b0;
        if (access) begin
            if (readEnable && writeEnable)
                err = 1'b1;
            else if (!dmem_hit && !io_hit)
                err = 1'b1;
            else if (!dmem_hit && io_hit && (address[1:0] != 2'b00))
                err = 1'b1;
        end
        rd_ok           = readEnable && !err;
        io_wr           = writeEnable && !err && !dmem_hit && io_hit;
        dmemReadEnable  = readEnable && dmem_hit && !err;
        dmemWriteEnable = writeEnable && dmem_hit && !err;
    end

    assign dmemAddress   = address[DMEM_AW-1:0] - DMEM_BASE[DMEM_AW-1:0];
    assign dmemWriteData = writeData;

    // I/O read mux; bits above each register's width read as zero
    always_comb begin
        io_rdata = '0;
        case (address[3:2])
            REG_SW_VAL:  io_rdata[SW_W-1:0]  = sw_val;
            REG_SW_EDGE: io_rdata[SW_W-1:0]  = sw_edge;
            REG_LED:     io_rdata[LED_W-1:0] = led_reg;
            REG_SEG:     io_rdata[15:0]      = seg_reg;
            default:     io_rdata            = '0;
        endcase
    end

    // Read response: capture load data on an accepted read, pulse valid/error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readData  <= '0;
            readValid <= 1'b0;
            busError  <= 1'b0;
        end else begin
            readValid <= rd_ok;
            busError  <= err;
            if (rd_ok)
                readData <= dmem_hit ? dmemReadData : io_rdata;
        end
    end

    // LED and 7-segment registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_reg <= '0;
            seg_reg <= '0;
        end else if (io_wr) begin
            if (address[3:2] == REG_LED)
                led_reg <= writeData[LED_W-1:0];
            if (address[3:2] == REG_SEG)
                seg_reg <= writeData[15:0];
        end
    end

    assign leds     = led_reg;
    assign segValue = seg_reg;

    // Debounce terminal count and change-flag update masks
    always_comb begin
        deb_fire  = (sync != sw_val) && (cnt == CNT_LAST);
        edge_set  = deb_fire ? (sw_val ^ sync) : '0;
        edge_clr  = (io_wr && (address[3:2] == REG_SW_EDGE)) ? writeData[SW_W-1:0] : '0;
        // A flag raised in the same cycle it is cleared survives
        edge_next = (sw_edge & ~edge_clr) | edge_set;
    end

    // Switch synchroniser and shared debounce counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync   <= '0;
            sw_val <= '0;
            cnt    <= '0;
        end else begin
            sync_a <= switches;
            sync   <= sync_a;
            if (sync == sw_val) begin
                cnt <= '0;
            end else if (deb_fire) begin
                sw_val <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Sticky change flags; the interrupt is registered from the same next value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_edge <= '0;
            swIrq   <= 1'b0;
        end else begin
            sw_edge <= edge_next;
            swIrq   <= |edge_next;
        end
    end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Bench for mmio_io_hub: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the register map.
module tb_mmio_io_hub;

    localparam int          DEB       = 8;
    localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
    localparam int          DMEM_AW   = 9;
    localparam logic [31:0] IO_BASE   = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic        readEnable = 1'b0;
    logic        writeEnable = 1'b0;
    logic [31:0] writeData = '0;
    logic [31:0] readData;
    logic        readValid;
    logic        busError;
    logic [15:0] switches = '0;
    logic [15:0] leds;
    logic [15:0] segValue;
    logic        swIrq;
    logic        dmemReadEnable;
    logic        dmemWriteEnable;
    logic [8:0]  dmemAddress;
    logic [31:0] dmemWriteData;
    logic [31:0] dmemReadData = '0;

    mmio_io_hub #(
        .ADDR_W(32), .DATA_W(32), .SW_W(16), .LED_W(16),
        .DMEM_BASE(DMEM_BASE), .DMEM_AW(DMEM_AW), .IO_BASE(IO_BASE),
        .DEBOUNCE_CYC(DEB)
    ) dut (
        .clk(clk), .rst(rst), .address(address),
        .readEnable(readEnable), .writeEnable(writeEnable),
        .writeData(writeData), .readData(readData), .readValid(readValid),
        .busError(busError), .switches(switches), .leds(leds),
        .segValue(segValue), .swIrq(swIrq),
        .dmemReadEnable(dmemReadEnable), .dmemWriteEnable(dmemWriteEnable),
        .dmemAddress(dmemAddress), .dmemWriteData(dmemWriteData),
        .dmemReadData(dmemReadData)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [15:0] m_sw, m_edge, m_led, m_seg, m_s1, m_s2;
    logic [31:0] m_rdata;
    logic        m_rvalid, m_berr;
    int          m_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_dmem(input logic [31:0] a);
        longint la = longint'(a);
        longint lb = longint'(DMEM_BASE);
        return (la >= lb) && (la < lb + (longint'(1) << DMEM_AW));
    endfunction

    function automatic bit is_io(input logic [31:0] a);
        longint la = longint'(a);
        longint lb = longint'(IO_BASE);
        return (la >= lb) && (la < lb + 16);
    endfunction

    function automatic bit is_err(input logic [31:0] a, input logic re, input logic we);
        if (!re && !we) return 1'b0;
        if (re && we) return 1'b1;
        if (is_dmem(a)) return 1'b0;
        if (is_io(a)) return (a % 4) != 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] io_value(input logic [31:0] a);
        case ((a - IO_BASE) / 4)
            0: return {16'h0, m_sw};
            1: return {16'h0, m_edge};
            2: return {16'h0, m_led};
            default: return {16'h0, m_seg};
        endcase
    endfunction

    task automatic model_reset();
        m_sw = '0; m_edge = '0; m_led = '0; m_seg = '0; m_s1 = '0; m_s2 = '0;
        m_rdata = '0; m_rvalid = 1'b0; m_berr = 1'b0; m_run = 0;
    endtask

    // Advance the model by one clock edge using the inputs present before it
    task automatic model_step();
        logic        e;
        logic [15:0] setm, clrm;
        logic [31:0] off;
        e = is_err(address, readEnable, writeEnable);
        setm = '0;
        clrm = '0;
        if (readEnable && !e)
            m_rdata = is_dmem(address) ? dmemReadData : io_value(address);
        m_rvalid = readEnable && !e;
        m_berr = e;
        if (writeEnable && !e && !is_dmem(address)) begin
            off = address - IO_BASE;
            if (off == 8) m_led = writeData[15:0];
            if (off == 12) m_seg = writeData[15:0];
            if (off == 4) clrm = writeData[15:0];
        end
        if (m_s2 != m_sw) begin
            m_run++;
            if (m_run == DEB) begin
                setm = m_sw ^ m_s2;
                m_sw = m_s2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_edge = (m_edge & ~clrm) | setm;
        m_s2 = m_s1;
        m_s1 = switches;
    endtask

    // One clock: check strobes before the edge, step model, check registered outputs after
    task automatic cycle();
        logic e, dh;
        #1;
        e = is_err(address, readEnable, writeEnable);
        dh = is_dmem(address);
        chk("dmemReadEnable", {31'h0, dmemReadEnable}, {31'h0, readEnable && dh && !e});
        chk("dmemWriteEnable", {31'h0, dmemWriteEnable}, {31'h0, writeEnable && dh && !e});
        if (dh) chk("dmemAddress", {23'h0, dmemAddress}, (address - DMEM_BASE) % 512);
        chk("dmemWriteData", dmemWriteData, writeData);
        @(posedge clk);
        model_step();
        #1;
        chk("readData", readData, m_rdata);
        chk("readValid", {31'h0, readValid}, {31'h0, m_rvalid});
        chk("busError", {31'h0, busError}, {31'h0, m_berr});
        chk("leds", {16'h0, leds}, {16'h0, m_led});
        chk("segValue", {16'h0, segValue}, {16'h0, m_seg});
        chk("swIrq", {31'h0, swIrq}, {31'h0, |m_edge});
    endtask

    task automatic idle();
        readEnable = 1'b0; writeEnable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        address = a; readEnable = 1'b1; writeEnable = 1'b0;
        cycle();
        idle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address = a; writeData = d; readEnable = 1'b0; writeEnable = 1'b1;
        cycle();
        idle();
    endtask

    task automatic idle_cycles(input int n);
        idle();
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [15:0] led_before, seg_before;

    initial begin
        model_reset();

        // Reset with switches high: every output low
        switches = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readData", readData, 32'h0);
        chk("rst_readValid", {31'h0, readValid}, 32'h0);
        chk("rst_busError", {31'h0, busError}, 32'h0);
        chk("rst_leds", {16'h0, leds}, 32'h0);
        chk("rst_seg", {16'h0, segValue}, 32'h0);
        chk("rst_irq", {31'h0, swIrq}, 32'h0);
        rst = 1'b1;

        // Poll SW_VAL until the debounced value appears
        for (int i = 0; i < DEB + 3; i++) rd(IO_BASE);
        chk("sw_val_after_debounce", readData, 32'h0000_FFFF);
        rd(IO_BASE + 4);
        chk("sw_edge_after_debounce", readData, 32'h0000_FFFF);
        wr(IO_BASE + 4, 32'hFFFF);
        switches = 16'h0000;
        idle_cycles(DEB + 3);
        wr(IO_BASE + 4, 32'hFFFF);
        chk("irq_cleared", {31'h0, swIrq}, 32'h0);

        // LED write then read-back
        wr(IO_BASE + 8, 32'h0000_1234);
        chk("leds_written", {16'h0, leds}, 32'h1234);
        rd(IO_BASE + 8);
        chk("led_readback", readData, 32'h0000_1234);
        wr(IO_BASE + 12, 32'hABCD_5A5A);
        rd(IO_BASE + 12);
        chk("seg_readback", readData, 32'h0000_5A5A);

        // Data-memory read
        dmemReadData = 32'hDEADBEEF;
        rd(DMEM_BASE + 32'h10);
        chk("dmem_read", readData, 32'hDEADBEEF);
        idle_cycles(1);
        chk("read_holds", readData, 32'hDEADBEEF);

        // Bounce on switch[3] shorter than the debounce time
        switches = 16'h0008;
        idle_cycles(DEB / 2);
        switches = 16'h0000;
        idle_cycles(DEB + 3);
        rd(IO_BASE);
        chk("bounce_ignored", readData, 32'h0);
        switches = 16'h0008;
        idle_cycles(DEB + 3);
        rd(IO_BASE);
        chk("sw3_set", readData, 32'h0008);
        rd(IO_BASE + 4);
        chk("edge3_set", readData, 32'h0008);
        chk("irq_set", {31'h0, swIrq}, 32'h1);
        wr(IO_BASE + 4, 32'h8);
        chk("irq_w1c", {31'h0, swIrq}, 32'h0);

        // Illegal accesses: no side effects
        led_before = leds;
        seg_before = segValue;
        rd(IO_BASE + 2);
        chk("err_misaligned", {31'h0, busError}, 32'h1);
        rd(32'h0000_1000);
        chk("err_unmapped", {31'h0, busError}, 32'h1);
        chk("err_no_valid", {31'h0, readValid}, 32'h0);
        address = IO_BASE + 8; writeData = 32'hFFFF_FFFF;
        readEnable = 1'b1; writeEnable = 1'b1;
        cycle();
        idle();
        chk("err_both", {31'h0, busError}, 32'h1);
        wr(32'h0000_1008, 32'h7777);
        chk("led_unchanged", {16'h0, leds}, {16'h0, led_before});
        chk("seg_unchanged", {16'h0, segValue}, {16'h0, seg_before});

        // Debounce update of bit 3 coinciding with a clear of bit 3
        switches = 16'h0000;
        idle_cycles(DEB + 1);
        wr(IO_BASE + 4, 32'h8);
        rd(IO_BASE + 4);
        chk("set_beats_clear", readData, 32'h0008);
        chk("irq_set_beats_clear", {31'h0, swIrq}, 32'h1);
        wr(IO_BASE + 4, 32'h8);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: address = DMEM_BASE + $urandom_range(0, 511);
                3, 4, 5, 6: address = IO_BASE + 4 * $urandom_range(0, 3);
                7: address = IO_BASE + $urandom_range(0, 15);
                8: address = 32'h0000_0210 + $urandom_range(0, 64);
                default: address = $urandom;
            endcase
            sel = $urandom_range(0, 9);
            readEnable = (sel < 4) || (sel == 9);
            writeEnable = (sel >= 4 && sel < 7) || (sel == 9);
            writeData = $urandom;
            dmemReadData = $urandom;
            if ($urandom_range(0, 24) == 0) switches = switches ^ 16'(1 << $urandom_range(0, 15));
            cycle();
        end
        idle();

        // Asynchronous reset between edges drops a pending read response
        rd(IO_BASE + 8);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_readValid", {31'h0, readValid}, 32'h0);
        chk("midrst_leds", {16'h0, leds}, 32'h0);
        chk("midrst_irq", {31'h0, swIrq}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
